// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per clock, writing its result back to the register file in a single-cycle pulse.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    input  logic [4:0]       rd_addr,
    output logic             busy,
    output logic             done,
    output logic             WE3,
    output logic [4:0]       AD3,
    output logic [WIDTH-1:0] WD3
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r, state_nxt;

    logic [CW-1:0]      cnt_r;
    logic [2:0]         op_r;
    logic [4:0]         rd_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               div0_r;
    logic               ovf_r;

    logic               a_sgn_s;
    logic               b_sgn_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   result_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            abs_val = -x;
        end else begin
            abs_val = x;
        end
    endfunction

    // a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
    assign a_sgn_s = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_sgn_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CALC;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide
    always_comb begin
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, b_r};
        if (op_r[2]) begin
            if (!diff_s[WIDTH]) begin
                acc_nxt_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction and special-case override of the final iteration's value
    always_comb begin
        prod_s = neg_res_r ? -acc_nxt_s : acc_nxt_s;
        quo_s  = acc_nxt_s[WIDTH-1:0];
        rem_s  = acc_nxt_s[2*WIDTH-1:WIDTH];
        case (op_r)
            3'b000:                 result_s = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result_s = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (div0_r) begin
                    result_s = {WIDTH{1'b1}};
                end else if (ovf_r) begin
                    result_s = {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    result_s = neg_res_r ? -quo_s : quo_s;
                end
            end
            3'b110, 3'b111: begin
                if (div0_r) begin
                    result_s = a_r;
                end else if (ovf_r) begin
                    result_s = {WIDTH{1'b0}};
                end else begin
                    result_s = neg_rem_r ? -rem_s : rem_s;
                end
            end
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    // Operand capture, iteration, and registered writeback outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            op_r      <= 3'd0;
            rd_r      <= 5'd0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            WE3       <= 1'b0;
            AD3       <= 5'd0;
            WD3       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= funct3;
                        rd_r      <= rd_addr;
                        a_r       <= RD1;
                        b_r       <= abs_val(RD2, b_sgn_s);
                        acc_r     <= {{WIDTH{1'b0}}, abs_val(RD1, a_sgn_s)};
                        cnt_r     <= {CW{1'b0}};
                        neg_res_r <= (a_sgn_s & RD1[WIDTH-1]) ^ (b_sgn_s & RD2[WIDTH-1]);
                        neg_rem_r <= a_sgn_s & RD1[WIDTH-1];
                        div0_r    <= (RD2 == {WIDTH{1'b0}});
                        ovf_r     <= funct3[2] && !funct3[0] &&
                                     (RD1 == {1'b1, {(WIDTH-1){1'b0}}}) && (RD2 == {WIDTH{1'b1}});
                        busy      <= 1'b1;
                    end
                end
                CALC: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        done <= 1'b1;
                        WE3  <= (rd_r != 5'd0);
                        AD3  <= rd_r;
                        WD3  <= result_s;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    WE3  <= 1'b0;
                    AD3  <= 5'd0;
                    WD3  <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule
